// File: rtl/pulse_stretcher_pkg.sv
// Shared types and constants for the pulse stretcher.
// Optional feature macro: PULSE_STRETCH_RETRIG_EN (see pulse_stretcher.sv).
package pulse_stretcher_pkg;

  localparam int CNT_W         = 8;
  localparam int PEND_W        = 4;
  localparam int DEF_WIDTH_CYC = 8;
  localparam int DEF_GAP_CYC   = 2;
  localparam int DEF_PEND_MAX  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_stretcher_cyc_down_counter.sv
// Loadable phase down-counter with zero flag; saturates at zero instead of wrapping.
// Optional feature macro: none (PULSE_STRETCH_RETRIG_EN only affects the top).
module cyc_down_counter
  import pulse_stretcher_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Trigger-to-pulse stretcher with enforced low gap and a saturating trigger queue.
// Define PULSE_STRETCH_RETRIG_EN to make triggers during ACTIVE extend the pulse.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int WIDTH_CYC = DEF_WIDTH_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int PEND_MAX  = DEF_PEND_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic              ovf_clr,
  output logic              pulse_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [CNT_W-1:0]  WIDTH_LOAD = CNT_W'(WIDTH_CYC - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'(GAP_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_LIM   = PEND_W'(PEND_MAX);

  state_e            state_q, state_d;
  logic              pulse_q, busy_q, ovf_q, ovf_d, ovf_set;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              cnt_load, cnt_dec, cnt_zero, enq, deq;
  logic [CNT_W-1:0]  cnt_val;

  cyc_down_counter u_phase_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    enq      = 1'b0;
    deq      = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d  = ACTIVE;
          cnt_load = 1'b1;
          cnt_val  = WIDTH_LOAD;
        end
      end
      ACTIVE: begin
`ifdef PULSE_STRETCH_RETRIG_EN
        if (trigger) begin
          cnt_load = 1'b1;
          cnt_val  = WIDTH_LOAD;
        end else if (cnt_zero) begin
          state_d  = GAP;
          cnt_load = 1'b1;
          cnt_val  = GAP_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
`else
        enq = trigger;
        if (cnt_zero) begin
          state_d  = GAP;
          cnt_load = 1'b1;
          cnt_val  = GAP_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
`endif
      end
      GAP: begin
        enq = trigger;
        if (cnt_zero) begin
          if (pend_q != '0) begin
            state_d  = ACTIVE;
            cnt_load = 1'b1;
            cnt_val  = WIDTH_LOAD;
            deq      = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A trigger landing on the dequeue edge takes the freed slot, so it never overflows.
  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (enq && !deq) begin
      if (pend_q == PEND_LIM) begin
        ovf_set = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (deq && !enq) begin
      pend_d = pend_q - PEND_W'(1);
    end
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= (state_d == ACTIVE);
      busy_q  <= (state_d != IDLE);
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher (WIDTH_CYC=8, GAP_CYC=2, PEND_MAX=3).
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       pulse_out, busy, overflow;
  logic [3:0] pending;

  int checks = 0;
  int passes = 0;

  bit trace[$];
  int exp_w[$], exp_g[$], meas_w[$], meas_g[$];
  int n_ones;

  pulse_stretcher #(.WIDTH_CYC(8), .GAP_CYC(2), .PEND_MAX(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .trigger   (trigger),
    .ovf_clr   (ovf_clr),
    .pulse_out (pulse_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    trace.push_back(pulse_out);
  endtask

  // Turns the recorded pulse_out trace into completed pulse widths and inter-pulse gaps.
  function automatic void extract();
    int  run = 0;
    int  low = 0;
    bit  seen = 0;
    meas_w.delete();
    meas_g.delete();
    n_ones = 0;
    foreach (trace[i]) begin
      if (trace[i]) begin
        n_ones++;
        if (run == 0 && seen) meas_g.push_back(low);
        run++;
        low = 0;
      end else begin
        if (run > 0) begin
          meas_w.push_back(run);
          seen = 1;
        end
        run = 0;
        low++;
      end
    end
  endfunction

  task automatic clear_sb();
    trace.delete();
    exp_w.delete();
    exp_g.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    trigger = 1'b1;
    tick();
    tick();
    checks++; if (pulse_out !== 1'b0) $display("FAIL reset_pulse: got %b want 0", pulse_out); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (pending !== 4'd0) $display("FAIL reset_pending: got %0d want 0", pending); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passes++;
    reset = 1'b0;
    trigger = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL reset_trig_discard: busy got %b want 0", busy); else passes++;
  endtask

  task automatic test_single();
    int ew, mw;
    clear_sb();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    exp_w.push_back(8);
    checks++; if (pulse_out !== 1'b1) $display("FAIL single_rise: got %b want 1", pulse_out); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else passes++;
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++; if (pending !== 4'd0) $display("FAIL single_pend: cyc %0d got %0d want 0", i, pending); else passes++;
    end
    tick();
    checks++; if (pulse_out !== 1'b0 || busy !== 1'b1) $display("FAIL single_gap0: pulse %b busy %b want 0/1", pulse_out, busy); else passes++;
    tick();
    checks++; if (pulse_out !== 1'b0 || busy !== 1'b1) $display("FAIL single_gap1: pulse %b busy %b want 0/1", pulse_out, busy); else passes++;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL single_idle: busy got %b want 0", busy); else passes++;
    repeat (5) tick();
    extract();
    checks++; if (meas_w.size() !== exp_w.size()) $display("FAIL single_count: got %0d want %0d", meas_w.size(), exp_w.size()); else passes++;
    while (exp_w.size() > 0 && meas_w.size() > 0) begin
      ew = exp_w.pop_front(); mw = meas_w.pop_front();
      checks++; if (mw !== ew) $display("FAIL single_width: got %0d want %0d", mw, ew); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int ew, mw;
    clear_sb();
    trigger = 1'b1;
    tick();
    tick();
    trigger = 1'b0;
    exp_w.push_back(8); exp_w.push_back(8); exp_g.push_back(2);
    checks++; if (pending !== 4'd1) $display("FAIL b2b_pend1: got %0d want 1", pending); else passes++;
    repeat (8) tick();
    checks++; if (pending !== 4'd1 || pulse_out !== 1'b0) $display("FAIL b2b_gap_end: pend %0d pulse %b want 1/0", pending, pulse_out); else passes++;
    tick();
    checks++; if (pending !== 4'd0 || pulse_out !== 1'b1) $display("FAIL b2b_dequeue: pend %0d pulse %b want 0/1", pending, pulse_out); else passes++;
    repeat (15) tick();
    extract();
    checks++; if (meas_w.size() !== exp_w.size()) $display("FAIL b2b_count: got %0d want %0d", meas_w.size(), exp_w.size()); else passes++;
    while (exp_w.size() > 0 && meas_w.size() > 0) begin
      ew = exp_w.pop_front(); mw = meas_w.pop_front();
      checks++; if (mw !== ew) $display("FAIL b2b_width: got %0d want %0d", mw, ew); else passes++;
    end
    while (exp_g.size() > 0 && meas_g.size() > 0) begin
      ew = exp_g.pop_front(); mw = meas_g.pop_front();
      checks++; if (mw !== ew) $display("FAIL b2b_gap: got %0d want %0d", mw, ew); else passes++;
    end
    checks++; if (exp_g.size() !== 0) $display("FAIL b2b_gap_missing: got %0d want 0 left", exp_g.size()); else passes++;
  endtask

  task automatic test_overflow();
    int ew, mw;
    clear_sb();
    trigger = 1'b1;
    repeat (4) tick();
    checks++; if (pending !== 4'd3 || overflow !== 1'b0) $display("FAIL ovf_fill: pend %0d ovf %b want 3/0", pending, overflow); else passes++;
    tick();
    checks++; if (pending !== 4'd3 || overflow !== 1'b1) $display("FAIL ovf_set: pend %0d ovf %b want 3/1", pending, overflow); else passes++;
    tick();
    trigger = 1'b0;
    checks++; if (pending !== 4'd3) $display("FAIL ovf_sat: got %0d want 3", pending); else passes++;
    repeat (4) exp_w.push_back(8);
    repeat (3) exp_g.push_back(2);
    repeat (45) tick();
    extract();
    checks++; if (meas_w.size() !== exp_w.size()) $display("FAIL ovf_count: got %0d want %0d", meas_w.size(), exp_w.size()); else passes++;
    while (exp_w.size() > 0 && meas_w.size() > 0) begin
      ew = exp_w.pop_front(); mw = meas_w.pop_front();
      checks++; if (mw !== ew) $display("FAIL ovf_width: got %0d want %0d", mw, ew); else passes++;
    end
    while (exp_g.size() > 0 && meas_g.size() > 0) begin
      ew = exp_g.pop_front(); mw = meas_g.pop_front();
      checks++; if (mw !== ew) $display("FAIL ovf_gap: got %0d want %0d", mw, ew); else passes++;
    end
    checks++; if (overflow !== 1'b1 || busy !== 1'b0) $display("FAIL ovf_sticky: ovf %b busy %b want 1/0", overflow, busy); else passes++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_clr: got %b want 0", overflow); else passes++;

    clear_sb();
    trigger = 1'b1;
    repeat (4) tick();
    ovf_clr = 1'b1;
    tick();
    trigger = 1'b0;
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins: got %b want 1", overflow); else passes++;
    repeat (45) tick();
    extract();
    checks++; if (meas_w.size() !== 4) $display("FAIL ovf2_count: got %0d want 4", meas_w.size()); else passes++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) $display("FAIL ovf2_clr: got %b want 0", overflow); else passes++;
  endtask

  task automatic test_coincident();
    int ew, mw;
    clear_sb();
    trigger = 1'b1;
    tick();
    tick();
    trigger = 1'b0;
    repeat (8) tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (3) exp_w.push_back(8);
    repeat (2) exp_g.push_back(2);
    checks++; if (pending !== 4'd1 || pulse_out !== 1'b1) $display("FAIL coinc_pend: pend %0d pulse %b want 1/1", pending, pulse_out); else passes++;
    repeat (25) tick();
    extract();
    checks++; if (meas_w.size() !== exp_w.size()) $display("FAIL coinc_count: got %0d want %0d", meas_w.size(), exp_w.size()); else passes++;
    while (exp_w.size() > 0 && meas_w.size() > 0) begin
      ew = exp_w.pop_front(); mw = meas_w.pop_front();
      checks++; if (mw !== ew) $display("FAIL coinc_width: got %0d want %0d", mw, ew); else passes++;
    end
    while (exp_g.size() > 0 && meas_g.size() > 0) begin
      ew = exp_g.pop_front(); mw = meas_g.pop_front();
      checks++; if (mw !== ew) $display("FAIL coinc_gap: got %0d want %0d", mw, ew); else passes++;
    end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    trigger = 1'b1;
    repeat (3) tick();
    trigger = 1'b0;
    checks++; if (pending !== 4'd2) $display("FAIL rstmid_pend: got %0d want 2", pending); else passes++;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (pulse_out !== 1'b0 || pending !== 4'd0 || busy !== 1'b0)
      $display("FAIL rstmid_state: pulse %b pend %0d busy %b want 0/0/0", pulse_out, pending, busy);
    else passes++;
    trace.delete();
    repeat (30) tick();
    extract();
    checks++; if (n_ones !== 0) $display("FAIL rstmid_no_pulse: got %0d high cycles want 0", n_ones); else passes++;
  endtask

  task automatic test_retrig();
    int ew, mw;
    clear_sb();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (4) tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    exp_w.push_back(13);
    checks++; if (pending !== 4'd0 || pulse_out !== 1'b1) $display("FAIL retrig_pend: pend %0d pulse %b want 0/1", pending, pulse_out); else passes++;
    repeat (25) tick();
    extract();
    checks++; if (meas_w.size() !== exp_w.size()) $display("FAIL retrig_count: got %0d want %0d", meas_w.size(), exp_w.size()); else passes++;
    while (exp_w.size() > 0 && meas_w.size() > 0) begin
      ew = exp_w.pop_front(); mw = meas_w.pop_front();
      checks++; if (mw !== ew) $display("FAIL retrig_width: got %0d want %0d", mw, ew); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef PULSE_STRETCH_RETRIG_EN
    test_retrig();
`else
    test_back_to_back();
    test_overflow();
    test_coincident();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter WIDTH_CYC, default 8: high time of each output pulse, in clk cycles; legal range 1..255.
REQ-002 Parameter GAP_CYC, default 2: forced low time after each output pulse, in clk cycles; legal range 1..255.
REQ-003 Parameter PEND_MAX, default 3: saturation limit of the pending-trigger counter; legal range 1..15.
REQ-004 clk  input  1  single system clock; all logic updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 trigger  input  1  single-cycle strobe requesting one stretched pulse, sampled on every rising edge of clk.
REQ-007 ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 pulse_out  output  1  registered stretched level output.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 pending  output  4  count of queued triggers not yet serviced.
REQ-011 overflow  output  1  sticky flag; set when a trigger is dropped because the queue is saturated.

Function
REQ-012 The block SHALL implement a 3-state machine with states IDLE, ACTIVE and GAP.
REQ-013 In IDLE, trigger=1 at edge k SHALL move the state to ACTIVE and set pulse_out=1 from edge k, giving zero added latency beyond the register.
REQ-014 ACTIVE SHALL hold pulse_out=1 for exactly WIDTH_CYC cycles, then enter GAP with pulse_out=0.
REQ-015 GAP SHALL hold pulse_out=0 for exactly GAP_CYC cycles, so every output pulse is separated by at least GAP_CYC low cycles and a downstream rising-edge detector sees every pulse.
REQ-016 At the end of GAP with pending>0, the block SHALL re-enter ACTIVE on the next edge and decrement pending by 1.
REQ-017 At the end of GAP with pending=0, the block SHALL return to IDLE.
REQ-018 trigger=1 while in ACTIVE or GAP SHALL increment pending.
REQ-019 If pending=PEND_MAX when such a trigger arrives, the trigger SHALL be dropped, pending SHALL remain PEND_MAX, and overflow SHALL be set.
REQ-020 If a trigger arrives on the same edge that a pending trigger is dequeued, pending SHALL be unchanged.
REQ-021 ovf_clr=1 SHALL clear overflow on the next edge.
REQ-022 If ovf_clr and a new overflow event occur on the same edge, set SHALL win over clear.
REQ-023 trigger held high for N cycles SHALL be treated as N separate triggers; the block does not perform edge detection.
REQ-024 The phase counter SHALL be 8 bits, load WIDTH_CYC-1 or GAP_CYC-1 on entry to a state, and never wrap; the state exits when the counter reads 0.

Reset
REQ-025 When reset=1 at an edge, the next values SHALL be: state=IDLE, pulse_out=0, busy=0, pending=0, overflow=0, counter=0.
REQ-026 reset SHALL take priority over trigger and ovf_clr; a trigger on a reset edge is discarded.
REQ-027 Reset asserted mid-ACTIVE SHALL drop pulse_out on the following edge and discard all queued triggers.

Configuration
REQ-028 With the macro PULSE_STRETCH_RETRIG_EN defined, trigger=1 in ACTIVE SHALL reload the counter to WIDTH_CYC-1, extending the current pulse, and SHALL NOT change pending.
REQ-029 With PULSE_STRETCH_RETRIG_EN defined, triggers in GAP SHALL still queue per REQ-018 to REQ-020.
REQ-030 Without PULSE_STRETCH_RETRIG_EN, triggers in ACTIVE SHALL queue per REQ-018 to REQ-020.

Structure
REQ-031 Package pulse_stretcher_pkg SHALL hold the state enum typedef (IDLE/ACTIVE/GAP), the counter width constant (8), the pending width constant (4), and the default parameter values.
REQ-032 One sub-module, cyc_down_counter (loadable 8-bit down-counter with a zero flag), SHALL implement the phase counter; the remaining logic lives in pulse_stretcher.

Verification (WIDTH_CYC=8, GAP_CYC=2, PEND_MAX=3)
REQ-033 One trigger in IDLE -> pulse_out high exactly 8 cycles, then low 2 cycles with busy=1, then busy=0 with pending=0 throughout.
REQ-034 Triggers 1 cycle apart x2 -> two 8-cycle pulses separated by exactly 2 low cycles; pending reads 1, then 0 at the start of the second pulse.
REQ-035 5 triggers during one ACTIVE -> pending saturates at 3, overflow=1, and 4 total pulses are produced; ovf_clr pulse -> overflow=0 next cycle.
REQ-036 Trigger coincident with the dequeue edge at the end of GAP -> pending unchanged and an extra pulse follows.
REQ-037 Reset asserted at cycle 4 of ACTIVE with pending=2 -> pulse_out=0, pending=0, busy=0 next cycle, and no further pulses.
REQ-038 With PULSE_STRETCH_RETRIG_EN, a trigger at cycle 5 of ACTIVE -> single pulse 13 cycles high, pending stays 0.
